// File: rtl/rs232_pkg.sv
// Shared constants and FSM state encodings for the RS232 UART controller.
package rs232_pkg;

   // Parity modes
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Receiver states
   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_PAR     = 3'd3,
      RX_STOP    = 3'd4,
      RX_WAIT_HI = 3'd5
   } rx_state_t;

   // Transmitter states
   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_DATA  = 3'd2,
      TX_PAR   = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_t;

   // Value that (XOR of data bits XOR parity bit) must reach for a given mode
   function automatic logic parity_target(input int parity);
      return (parity == PARITY_ODD);
   endfunction

endpackage

// File: rtl/rs232_uart_rx.sv
// RS232 receiver: 2-flop synchronizer, mid-bit sampling on oversampling ticks,
// parity and framing checks, one-cycle strobe with held result registers.
module rs232_uart_rx
   import rs232_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY    = PARITY_ODD,
   parameter int STOP_BITS = 1,
   parameter int MSB_FIRST = 1,
   parameter int OVS       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              rx_i,
   output logic              new_word_o,
   output logic [DATA_W-1:0] data_o,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output rx_state_t         state_dbg_o
);

   localparam int             TW        = $clog2(OVS);
   localparam logic [TW-1:0]  TICK_LAST = TW'(OVS - 1);
   localparam logic [TW-1:0]  TICK_MID  = TW'(OVS / 2 - 1);
   localparam int             BW        = $clog2(DATA_W);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_W - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic           PAR_TGT   = parity_target(PARITY);

   logic              sync1_q, sync2_q;
   rx_state_t         state_q;
   logic [TW-1:0]     tick_q;
   logic [BW-1:0]     bit_q;
   logic              stop_q;
   logic [DATA_W-1:0] shreg_q;
   logic              par_bit_q;
   logic              ferr_acc_q;
   logic              new_word_q;
   logic [DATA_W-1:0] data_q;
   logic              perr_q;
   logic              ferr_q;

   logic [DATA_W-1:0] shreg_d;
   logic              perr_d;
   logic              ferr_d;

   // Bring the asynchronous line into the clk domain; idles high like the line
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
      end
   end

   // Shift-in of the sampled bit, and the verdicts for the completed frame
   always_comb begin
      shreg_d = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], sync2_q}
                                 : {sync2_q, shreg_q[DATA_W-1:1]};
      perr_d  = (PARITY == PARITY_NONE) ? 1'b0
                                        : ((^shreg_q ^ par_bit_q) != PAR_TGT);
      ferr_d  = ferr_acc_q | ~sync2_q;
   end

   // Receive FSM; every counter moves only on a tick, the strobe is cleared every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RX_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         stop_q     <= 1'b0;
         shreg_q    <= '0;
         par_bit_q  <= 1'b0;
         ferr_acc_q <= 1'b0;
         new_word_q <= 1'b0;
         data_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         new_word_q <= 1'b0;
         if (tick_i) begin
            case (state_q)
               RX_IDLE: begin
                  if (!sync2_q) begin
                     state_q <= RX_START;
                     tick_q  <= '0;
                  end
               end
               RX_START: begin
                  if (tick_q == TICK_MID) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     // a line already back high at mid-start is a glitch
                     state_q <= sync2_q ? RX_IDLE : RX_DATA;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               RX_DATA: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q  <= '0;
                     shreg_q <= shreg_d;
                     if (bit_q == BIT_LAST) begin
                        stop_q     <= 1'b0;
                        ferr_acc_q <= 1'b0;
                        state_q    <= (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
                     end else begin
                        bit_q <= bit_q + BW'(1);
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               RX_PAR: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q    <= '0;
                     par_bit_q <= sync2_q;
                     state_q   <= RX_STOP;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               RX_STOP: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q <= '0;
                     if (stop_q == STOP_LAST) begin
                        new_word_q <= 1'b1;
                        data_q     <= shreg_q;
                        perr_q     <= perr_d;
                        ferr_q     <= ferr_d;
                        // a low stop bit may be a break; wait for the line to recover
                        state_q    <= ferr_d ? RX_WAIT_HI : RX_IDLE;
                     end else begin
                        stop_q     <= stop_q + 1'b1;
                        ferr_acc_q <= ferr_d;
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               RX_WAIT_HI: begin
                  if (sync2_q) state_q <= RX_IDLE;
               end
               default: state_q <= RX_IDLE;
            endcase
         end
      end
   end

   assign new_word_o   = new_word_q;
   assign data_o       = data_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign state_dbg_o  = state_q;

endmodule

// File: rtl/rs232_uart_ctrl.sv
// RS232 UART controller: independent receiver (sub-module) and inline transmitter,
// both paced by a one-cycle oversampling tick clk_rs232_en.
//
// Transmit handshake: send_word is a request sampled on every clk edge. It is
// accepted only on an edge where tx_busy is low; data_rs232_out is latched on
// that edge and tx_busy is high from the next cycle until the cycle after the
// last stop-bit tick. Requests while tx_busy is high are dropped, not queued.
module rs232_uart_ctrl
   import rs232_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY    = PARITY_ODD,
   parameter int STOP_BITS = 1,
   parameter int MSB_FIRST = 1,
   parameter int OVS       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_rs232_en,
   input  logic              send_word,
   input  logic [DATA_W-1:0] data_rs232_out,
   output logic              tx_busy,
   output logic              new_word,
   output logic [DATA_W-1:0] data_rs232_in,
   output logic              parity_err,
   output logic              frame_err,
   input  logic              rx,
   output logic              tx,
   output rx_state_t         rx_state_dbg,
   output tx_state_t         tx_state_dbg
);

   localparam int             TW        = $clog2(OVS);
   localparam logic [TW-1:0]  TICK_LAST = TW'(OVS - 1);
   localparam int             BW        = $clog2(DATA_W);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_W - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic           PAR_TGT   = parity_target(PARITY);

   rs232_uart_rx #(
      .DATA_W    (DATA_W),
      .PARITY    (PARITY),
      .STOP_BITS (STOP_BITS),
      .MSB_FIRST (MSB_FIRST),
      .OVS       (OVS)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (clk_rs232_en),
      .rx_i         (rx),
      .new_word_o   (new_word),
      .data_o       (data_rs232_in),
      .parity_err_o (parity_err),
      .frame_err_o  (frame_err),
      .state_dbg_o  (rx_state_dbg)
   );

   tx_state_t         tx_state_q;
   logic [TW-1:0]     tx_tick_q;
   logic [BW-1:0]     tx_bit_q;
   logic              tx_stop_q;
   logic [DATA_W-1:0] tx_shreg_q;
   logic              tx_par_q;
   logic              tx_q;
   logic              tx_busy_q;

   logic              tx_next_bit_d;
   logic [DATA_W-1:0] tx_shift_d;

   // Next data bit to put on the line and the register after it leaves
   always_comb begin
      tx_next_bit_d = (MSB_FIRST != 0) ? tx_shreg_q[DATA_W-1] : tx_shreg_q[0];
      tx_shift_d    = (MSB_FIRST != 0) ? {tx_shreg_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, tx_shreg_q[DATA_W-1:1]};
   end

   // Transmit FSM with registered line and busy flag; each bit holds for OVS ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_stop_q  <= 1'b0;
         tx_shreg_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else if (tx_state_q == TX_IDLE) begin
         tx_q <= 1'b1;
         if (send_word) begin
            tx_shreg_q <= data_rs232_out;
            tx_par_q   <= ^data_rs232_out ^ PAR_TGT;
            tx_tick_q  <= '0;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= TX_START;
         end
      end else if (clk_rs232_en) begin
         if (tx_tick_q != TICK_LAST) begin
            tx_tick_q <= tx_tick_q + TW'(1);
         end else begin
            tx_tick_q <= '0;
            case (tx_state_q)
               TX_START: begin
                  tx_q       <= tx_next_bit_d;
                  tx_shreg_q <= tx_shift_d;
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_DATA;
               end
               TX_DATA: begin
                  if (tx_bit_q == BIT_LAST) begin
                     tx_stop_q <= 1'b0;
                     if (PARITY != PARITY_NONE) begin
                        tx_q       <= tx_par_q;
                        tx_state_q <= TX_PAR;
                     end else begin
                        tx_q       <= 1'b1;
                        tx_state_q <= TX_STOP;
                     end
                  end else begin
                     tx_bit_q   <= tx_bit_q + BW'(1);
                     tx_q       <= tx_next_bit_d;
                     tx_shreg_q <= tx_shift_d;
                  end
               end
               TX_PAR: begin
                  tx_q       <= 1'b1;
                  tx_stop_q  <= 1'b0;
                  tx_state_q <= TX_STOP;
               end
               TX_STOP: begin
                  if (tx_stop_q == STOP_LAST) begin
                     tx_busy_q  <= 1'b0;
                     tx_state_q <= TX_IDLE;
                  end else begin
                     tx_stop_q <= tx_stop_q + 1'b1;
                  end
               end
               default: begin
                  tx_q       <= 1'b1;
                  tx_busy_q  <= 1'b0;
                  tx_state_q <= TX_IDLE;
               end
            endcase
         end
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = tx_busy_q;
   assign tx_state_dbg = tx_state_q;

endmodule

// File: tb/tb_rs232_uart_ctrl.sv
// Bench for rs232_uart_ctrl at default parameters (8 data bits, odd parity,
// 1 stop bit, MSB first, 16 ticks per bit).
module tb_rs232_uart_ctrl;
   import rs232_pkg::*;

   localparam int OVS_TB = 16;
   localparam int NBITS  = 11;             // start + 8 data + parity + stop
   localparam int TOTAL  = NBITS * OVS_TB; // ticks per frame
   localparam int DIV    = 3;              // clk cycles per oversampling tick

   // ---------------- clock / reset / tick ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_rs232_en = 1'b0;
   logic       send_word = 1'b0;
   logic [7:0] data_rs232_out = 8'h00;
   logic       rx = 1'b1;
   logic       tx_busy, new_word, parity_err, frame_err, tx;
   logic [7:0] data_rs232_in;
   rx_state_t  rx_state_dbg;
   tx_state_t  tx_state_dbg;

   always #5 clk = ~clk;

   initial begin
      int div = 0;
      forever begin
         @(posedge clk);
         #2;
         clk_rs232_en = (div == DIV - 1);
         div = (div == DIV - 1) ? 0 : div + 1;
      end
   end

   rs232_uart_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .clk_rs232_en   (clk_rs232_en),
      .send_word      (send_word),
      .data_rs232_out (data_rs232_out),
      .tx_busy        (tx_busy),
      .new_word       (new_word),
      .data_rs232_in  (data_rs232_in),
      .parity_err     (parity_err),
      .frame_err      (frame_err),
      .rx             (rx),
      .tx             (tx),
      .rx_state_dbg   (rx_state_dbg),
      .tx_state_dbg   (tx_state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [9:0]  rx_exp_q[$];   // {data, parity_err, frame_err}
   logic [10:0] tx_exp_q[$];   // line bit i at index i
   int          model_rem = 0; // ticks left in the frame the model believes is on the line
   logic        tx_post_rst = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: start 0, data MSB first, odd parity, one stop bit
   function automatic logic [10:0] make_frame(input logic [7:0] w);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = w[7 - i];
      f[9]  = (($countones(w) % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!clk_rs232_en) @(posedge clk);
      end
      #2;
   endtask

   task automatic drive_rx(input logic v, input int n);
      rx = v;
      wait_ticks(n);
   endtask

   task automatic rx_frame(input logic [7:0] w, input logic pbit, input logic stop_v,
                           input int stop_ticks, input int idle_ticks);
      logic perr;
      perr = ((($countones(w) + int'(pbit)) % 2) != 1);
      rx_exp_q.push_back({w, perr, ~stop_v});
      drive_rx(1'b0, OVS_TB);
      for (int i = 7; i >= 0; i--) drive_rx(w[i], OVS_TB);
      drive_rx(pbit, OVS_TB);
      drive_rx(stop_v, stop_ticks);
      drive_rx(1'b1, idle_ticks);
   endtask

   task automatic tx_send(input logic [7:0] w);
      data_rs232_out = w;
      send_word = 1'b1;
      step();
      send_word = 1'b0;
      data_rs232_out = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_tx_idle(input string name);
      int n = 0;
      while ((model_rem != 0 || tx_exp_q.size() != 0) && n < 4000) begin
         step();
         n++;
      end
      check(name, 32'(n >= 4000), 32'd0);
      repeat (4) step();
   endtask

   task automatic wait_rx_drain(input string name);
      int n = 0;
      while (rx_exp_q.size() != 0 && n < 4000) begin
         step();
         n++;
      end
      check(name, 32'(rx_exp_q.size()), 32'd0);
   endtask

   // Behavioural transmitter model: decides acceptance and tracks frame length in ticks
   always @(posedge clk) begin
      if (rst) begin
         model_rem = 0;
         tx_exp_q.delete();
      end else if (send_word && model_rem == 0) begin
         tx_exp_q.push_back(make_frame(data_rs232_out));
         model_rem = TOTAL;
      end else if (clk_rs232_en && model_rem > 0) begin
         model_rem--;
      end
   end

   // ---------------- monitors ----------------
   // Receive monitor: every strobe pops one expectation; between strobes results must hold
   initial begin
      logic [9:0] e;
      logic [9:0] last = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last = '0;
         end else if (new_word) begin
            if (rx_exp_q.size() == 0) begin
               check("rx_unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = rx_exp_q.pop_front();
               check("rx_data", 32'(data_rs232_in), 32'(e[9:2]));
               check("rx_parity_err", 32'(parity_err), 32'(e[1]));
               check("rx_frame_err", 32'(frame_err), 32'(e[0]));
               last = e;
            end
         end else begin
            check("rx_hold", 32'({data_rs232_in, parity_err, frame_err}), 32'(last));
         end
      end
   end

   // Transmit monitor: when the DUT goes busy, pop a frame and check the line tick by tick
   initial begin
      int          ticks = 0;
      logic        active = 1'b0;
      logic        just_done = 1'b0;
      logic [10:0] fr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
            just_done = 1'b0;
            tx_post_rst = 1'b1;
         end else begin
            if (tx_post_rst) begin
               check("tx_after_reset", 32'(tx), 32'd1);
               check("tx_busy_after_reset", 32'(tx_busy), 32'd0);
               tx_post_rst = 1'b0;
            end
            if (just_done) begin
               check("tx_busy_drop", 32'(tx_busy), 32'd0);
               check("tx_idle_line", 32'(tx), 32'd1);
               just_done = 1'b0;
            end else if (!active) begin
               if (tx_busy) begin
                  if (tx_exp_q.size() == 0) begin
                     check("tx_unexpected_frame", 32'd1, 32'd0);
                     fr = '1;
                  end else begin
                     fr = tx_exp_q.pop_front();
                  end
                  active = 1'b1;
                  ticks = 0;
               end else begin
                  check("tx_idle_line", 32'(tx), 32'd1);
               end
            end
            if (active) begin
               check("tx_bit", 32'(tx), 32'(fr[ticks / OVS_TB]));
               check("tx_busy_high", 32'(tx_busy), 32'd1);
               if (clk_rs232_en) ticks++;
               if (ticks == TOTAL) begin
                  active = 1'b0;
                  just_done = 1'b1;
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

   // ---------------- main stimulus ----------------
   initial begin
      int n;
      rst = 1'b1;
      repeat (4) step();
      rst = 1'b0;
      #1;
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_tx_busy", 32'(tx_busy), 32'd0);
      check("reset_new_word", 32'(new_word), 32'd0);
      check("reset_rx_state", 32'(rx_state_dbg), 32'(RX_IDLE));
      check("reset_tx_state", 32'(tx_state_dbg), 32'(TX_IDLE));
      repeat (3) step();

      // directed receive frames
      rx_frame(8'h0D, 1'b0, 1'b1, OVS_TB, 8);
      rx_frame(8'h0B, 1'b1, 1'b1, OVS_TB, 8);
      rx_frame(8'h55, 1'b1, 1'b0, 3 * OVS_TB, 8);   // break-like low line
      rx_frame(8'h0D, 1'b0, 1'b1, OVS_TB, 8);
      wait_rx_drain("rx_directed_drain");

      // start glitch shorter than half a bit
      drive_rx(1'b0, 4);
      drive_rx(1'b1, 24);
      check("rx_idle_after_glitch", 32'(rx_state_dbg), 32'(RX_IDLE));

      // directed transmit with a request during the frame
      tx_send(8'hA5);
      wait_ticks(40);
      tx_send(8'hFF);
      wait_tx_idle("tx_a5_drain");

      // back-to-back: request in the cycle tx_busy drops
      tx_send(8'h12);
      n = 0;
      while (model_rem != 0 && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
      end
      #1;
      tx_send(8'h34);
      wait_tx_idle("tx_b2b_drain");

      // reset during transmit data bit 3 with a partial receive frame in flight
      tx_send(8'h96);
      drive_rx(1'b0, OVS_TB);
      drive_rx(1'b1, OVS_TB);
      drive_rx(1'b0, OVS_TB);
      drive_rx(1'b1, OVS_TB);
      wait_ticks(5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      rx = 1'b1;
      #1;
      check("midframe_rst_rx_state", 32'(rx_state_dbg), 32'(RX_IDLE));
      check("midframe_rst_tx_state", 32'(tx_state_dbg), 32'(TX_IDLE));
      wait_ticks(2 * OVS_TB);
      tx_send(8'h3C);
      wait_tx_idle("tx_3c_drain");

      // randomized concurrent traffic
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [7:0] w;
               logic       p, bad;
               w   = 8'($urandom_range(0, 255));
               p   = 1'($urandom_range(0, 1));
               bad = ($urandom_range(0, 4) == 0);
               rx_frame(w, p, ~bad, bad ? $urandom_range(OVS_TB, 3 * OVS_TB) : OVS_TB,
                        $urandom_range(2, 20));
            end
         end
         begin
            for (int i = 0; i < 12; i++) begin
               repeat ($urandom_range(0, 300)) step();
               tx_send(8'($urandom_range(0, 255)));
            end
         end
      join
      wait_rx_drain("rx_random_drain");
      wait_tx_idle("tx_random_drain");

      check("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);
      check("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
